// File: rtl/md_issue_ctrl.sv
// ---------------------------------------------------------------------------
// md_issue_ctrl
//   Initiator side of the HI/LO multiply/divide unit interface, in the EX
//   stage. Issues start pulses and HI/LO write strobes to the unit, shadows
//   each multi-cycle operation with a down-counter, freezes the front of the
//   pipeline while the unit cannot accept or return data, and hands mfhi/mflo
//   data to the EX result mux.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset (shared with the unit)
//   ex_valid    EX holds a valid, unstalled instruction
//   ex_op[2:0]  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi/mflo
//   ex_lo_sel   for op 7: 1 = mflo, 0 = mfhi
//   rs_val      forwarded rs operand
//   rt_val      forwarded rt operand
//   flush       later-stage exception, kills the EX instruction this cycle
//   md_busy     busy from the unit (authoritative end of an operation)
//   md_hi/md_lo HI/LO contents from the unit
//   md_a/md_b   operands to the unit, registered on issue
//   md_mult     one-cycle multiply start pulse
//   md_div      one-cycle divide start pulse
//   md_signed   signedness of the most recent start
//   md_hiwrite  one-cycle HI write strobe (data on md_a)
//   md_lowrite  one-cycle LO write strobe (data on md_a)
//   md_read     qualifies an mfhi/mflo that completes this cycle
//   stall       freeze IF/ID/EX (combinational)
//   md_result   mfhi/mflo data (combinational)
//
// CNT_W must satisfy 2**CNT_W > DIV_CYCLES so the divide count fits.
// ---------------------------------------------------------------------------
module md_issue_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic        ex_lo_sel,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  output logic        md_mult,
  output logic        md_div,
  output logic        md_signed,
  output logic        md_hiwrite,
  output logic        md_lowrite,
  output logic        md_read,
  output logic        stall,
  output logic [31:0] md_result
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_MF    = 3'd7
  } op_t;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  op_t              op;
  logic             md_op;
  logic             pulse_now;
  logic             issue;

  assign op        = op_t'(ex_op);
  assign md_op     = ex_valid && (ex_op != 3'd0) && !flush;

  // Any strobe on the wire this cycle means the unit has not yet absorbed the
  // previous request, so a following md instruction must wait one cycle.
  assign pulse_now = md_mult | md_div | md_hiwrite | md_lowrite;

  assign stall     = md_op && ((state == RUN) || pulse_now);

  // stall can only be low for an md op in IDLE, so issue implies IDLE.
  assign issue     = md_op && !stall;

  assign md_read   = issue && (op == OP_MF);
  assign md_result = ex_lo_sel ? md_lo : md_hi;

  // NOTE: state and registered outputs use non-blocking assignments so every
  // register samples the pre-edge values; blocking here would let later
  // statements see already-updated state and break the cycle semantics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      md_a       <= '0;
      md_b       <= '0;
      md_mult    <= 1'b0;
      md_div     <= 1'b0;
      md_signed  <= 1'b0;
      md_hiwrite <= 1'b0;
      md_lowrite <= 1'b0;
    end else begin
      // Strobes are single-cycle: cleared unless re-issued below.
      md_mult    <= 1'b0;
      md_div     <= 1'b0;
      md_hiwrite <= 1'b0;
      md_lowrite <= 1'b0;

      unique case (state)
        IDLE: begin
          if (issue) begin
            unique case (op)
              OP_MULT, OP_MULTU: begin
                md_a      <= rs_val;
                md_b      <= rt_val;
                md_mult   <= 1'b1;
                md_signed <= (op == OP_MULT);
                cnt       <= CNT_MULT;
                state     <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                md_a      <= rs_val;
                md_b      <= rt_val;
                md_div    <= 1'b1;
                md_signed <= (op == OP_DIV);
                cnt       <= CNT_DIV;
                state     <= RUN;
              end
              OP_MTHI: begin
                md_a       <= rs_val;
                md_hiwrite <= 1'b1;
              end
              OP_MTLO: begin
                md_a       <= rs_val;
                md_lowrite <= 1'b1;
              end
              default: ; // mfhi/mflo is served combinationally
            endcase
          end
        end

        RUN: begin
          // The counter is only the nominal length; the unit's busy has the
          // last word, so the count parks at one until busy drops.
          if ((cnt == CNT_ONE) && !md_busy) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt != CNT_ONE) begin
            cnt <= cnt - CNT_ONE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
